hilo_ctrl: RTL and testbench

- Holds the architectural HI/LO register pair downstream of the multiply/divide datapath.
- Tracks an outstanding mult/div operation from issue to result, and raises a pipeline stall for any HI/LO access that must wait for it.
- Services MFHI/MFLO reads and MTHI/MTLO writes, with result bypass.
- Supports flush: a cancelled in-flight result is discarded when it arrives.

---
 rtl/hilo_if.sv | 33 +++
 rtl/hilo_ctrl.sv | 107 ++++++++++
 tb/tb_hilo_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/hilo_if.sv
// HI/LO controller request/response bundle.
// The master side is the pipeline, the slave side is hilo_ctrl.
interface hilo_if #(
  parameter int width = 32
) ();
  logic               issue;
  logic               flush;
  logic               md_valid;
  logic [2*width-1:0] md_result;
  logic               mfhi;
  logic               mflo;
  logic               mthi;
  logic               mtlo;
  logic [width-1:0]   wdata;
  logic               stall;
  logic [width-1:0]   rdata;
  logic               rvalid;
  logic [width-1:0]   hi;
  logic [width-1:0]   lo;
  logic               err;

  modport master (
    output issue, flush, md_valid, md_result,
    output mfhi, mflo, mthi, mtlo, wdata,
    input  stall, rdata, rvalid, hi, lo, err
  );

  modport slave (
    input  issue, flush, md_valid, md_result,
    input  mfhi, mflo, mthi, mtlo, wdata,
    output stall, rdata, rvalid, hi, lo, err
  );
endinterface

// File: rtl/hilo_ctrl.sv
// HI/LO register pair with mult/div tracking, stall, bypass and flush.
// Result arriving while cancelled is dropped; stray results set err.
module hilo_ctrl #(
  parameter int width = 32
) (
  input  logic   clk,
  input  logic   rst,
  hilo_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DISCARD
  } state_t;

  state_t           state, state_n;
  logic [width-1:0] hi_q, lo_q, rdata_q;
  logic [width-1:0] hi_n, lo_n, rdata_n;
  logic             rvalid_q, rvalid_n;
  logic             err_q, err_n;
  logic             req, stall, acc, md_wr;
  logic [width-1:0] res_hi, res_lo;

  assign res_hi = bus.md_result[2*width-1:width];
  assign res_lo = bus.md_result[width-1:0];

  assign req = bus.issue | bus.mfhi | bus.mflo
             | bus.mthi | bus.mtlo;

  // Flushed requests are squashed, never held.
  assign stall = !bus.flush & req
               & ((state == BUSY & !bus.md_valid)
                  | state == DISCARD);
  assign acc   = !bus.flush & !stall;
  assign md_wr = (state == BUSY) & bus.md_valid & !bus.flush;

  always_comb begin
    state_n  = state;
    hi_n     = hi_q;
    lo_n     = lo_q;
    rdata_n  = rdata_q;
    rvalid_n = 1'b0;
    err_n    = err_q;
    unique case (state)
      IDLE: begin
        if (bus.md_valid)
          err_n = 1'b1;
        if (acc & bus.issue)
          state_n = BUSY;
      end
      BUSY: begin
        if (bus.flush)
          state_n = bus.md_valid ? IDLE : DISCARD;
        else if (bus.md_valid)
          state_n = bus.issue ? BUSY : IDLE;
      end
      DISCARD: begin
        if (bus.md_valid)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (acc & (bus.mfhi | bus.mflo)) begin
      rvalid_n = 1'b1;
      if (bus.mfhi)
        rdata_n = md_wr ? res_hi : hi_q;
      else
        rdata_n = md_wr ? res_lo : lo_q;
    end
    // Program order: explicit writes land after the result.
    if (md_wr) begin
      hi_n = res_hi;
      lo_n = res_lo;
    end
    if (acc & bus.mthi)
      hi_n = bus.wdata;
    if (acc & bus.mtlo)
      lo_n = bus.wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      hi_q     <= '0;
      lo_q     <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_n;
      hi_q     <= hi_n;
      lo_q     <= lo_n;
      rdata_q  <= rdata_n;
      rvalid_q <= rvalid_n;
      err_q    <= err_n;
    end
  end

  assign bus.stall  = stall;
  assign bus.rdata  = rdata_q;
  assign bus.rvalid = rvalid_q;
  assign bus.hi     = hi_q;
  assign bus.lo     = lo_q;
  assign bus.err    = err_q;

endmodule

// File: tb/tb_hilo_ctrl.sv
// Bench for hilo_ctrl: directed scenarios plus random traffic
// checked against a flag-based behavioural model.
module tb_hilo_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  hilo_if #(.width(32)) bus ();

  hilo_ctrl #(.width(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // model: pend = op outstanding, want = its result is still wanted
  bit          pend, want;
  logic [31:0] m_hi, m_lo, m_rdata;
  bit          m_rvalid, m_err;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_regs(string tag);
    chk({tag, "_hi"}, bus.hi, m_hi);
    chk({tag, "_lo"}, bus.lo, m_lo);
    chk({tag, "_rvalid"}, bus.rvalid, m_rvalid);
    if (m_rvalid)
      chk({tag, "_rdata"}, bus.rdata, m_rdata);
    chk({tag, "_err"}, bus.err, m_err);
  endtask

  task automatic idle_inputs();
    bus.issue = 0; bus.flush = 0; bus.md_valid = 0;
    bus.md_result = '0; bus.mfhi = 0; bus.mflo = 0;
    bus.mthi = 0; bus.mtlo = 0; bus.wdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1;
    @(posedge clk);
    #1;
    pend = 0; want = 0; m_hi = 0; m_lo = 0;
    m_rdata = 0; m_rvalid = 0; m_err = 0;
    chk("rst_rdata", bus.rdata, 32'h0);
    chk_regs("rst");
    @(negedge clk);
    rst = 0;
  endtask

  // Drive one cycle at negedge, check stall, step the model, check regs.
  task automatic cyc(bit is, bit fl, bit mv, logic [63:0] res,
                     bit fh, bit fo, bit th, bit tl,
                     logic [31:0] wd, string tag);
    bit req, exp_stall, acc, mdw;
    bus.issue = is; bus.flush = fl; bus.md_valid = mv;
    bus.md_result = res; bus.mfhi = fh; bus.mflo = fo;
    bus.mthi = th; bus.mtlo = tl; bus.wdata = wd;
    #1;
    req = is | fh | fo | th | tl;
    exp_stall = !fl && req && pend && (!want || !mv);
    chk({tag, "_stall"}, bus.stall, exp_stall);
    acc = !fl && !exp_stall;
    mdw = pend && want && mv && !fl;
    m_rvalid = acc && (fh || fo);
    if (m_rvalid)
      m_rdata = fh ? (mdw ? res[63:32] : m_hi)
                   : (mdw ? res[31:0] : m_lo);
    if (mdw) begin
      m_hi = res[63:32];
      m_lo = res[31:0];
    end
    if (acc && th) m_hi = wd;
    if (acc && tl) m_lo = wd;
    if (!pend && mv) m_err = 1;
    if (fl) begin
      if (pend && want) begin
        if (mv) pend = 0;
        else    want = 0;
      end else if (pend && mv) begin
        pend = 0;
      end
    end else if (pend && mv) begin
      pend = acc && is;
      want = 1;
    end else if (!pend && acc && is) begin
      pend = 1;
      want = 1;
    end
    @(posedge clk);
    #1;
    chk_regs(tag);
    @(negedge clk);
  endtask

  initial begin
    idle_inputs();
    do_reset();

    // write HI, then read it back
    cyc(0,0,0,'0, 0,0,1,0, 32'h1234, "t1w");
    cyc(0,0,0,'0, 1,0,0,0, 0, "t1r");
    chk("t1_hi", bus.hi, 32'h1234);
    chk("t1_lo", bus.lo, 32'h0);
    chk("t1_rdata", bus.rdata, 32'h1234);

    // issue, mflo held until result returns
    cyc(1,0,0,'0, 0,0,0,0, 0, "t2i");
    for (int i = 1; i <= 4; i++)
      cyc(0,0,0,'0, 0,1,0,0, 0, "t2s");
    cyc(0,0,1,64'h0000_0002_FFFF_FFFE, 0,1,0,0, 0, "t2m");
    chk("t2_rdata", bus.rdata, 32'hFFFF_FFFE);
    chk("t2_hi", bus.hi, 32'h2);

    // flush while busy, late result discarded
    cyc(1,0,0,'0, 0,0,0,0, 0, "t3i");
    cyc(0,0,0,'0, 0,0,0,0, 0, "t3a");
    cyc(0,1,0,'0, 0,0,0,0, 0, "t3f");
    cyc(0,0,0,'0, 1,0,0,0, 0, "t3d");
    cyc(0,0,1,64'hDEAD_BEEF_0000_0001, 0,0,0,0, 0, "t3m");
    chk("t3_hi", bus.hi, 32'h2);
    chk("t3_err", bus.err, 1'b0);
    cyc(0,0,0,'0, 1,0,0,0, 0, "t3r");

    // result + mthi + new issue in one cycle
    cyc(1,0,0,'0, 0,0,0,0, 0, "t4i");
    cyc(1,0,1,64'h1111_1111_2222_2222, 0,0,1,0, 32'h5, "t4m");
    chk("t4_hi", bus.hi, 32'h5);
    chk("t4_lo", bus.lo, 32'h2222_2222);
    cyc(0,0,0,'0, 1,0,0,0, 0, "t4busy");

    // reset while busy, then read
    do_reset();
    cyc(0,0,0,'0, 1,0,0,0, 0, "t6r");
    chk("t6_rdata", bus.rdata, 32'h0);

    // stray result in idle
    cyc(0,0,1,64'hAAAA_AAAA_BBBB_BBBB, 0,0,0,0, 0, "t5m");
    chk("t5_err", bus.err, 1'b1);
    cyc(0,0,0,'0, 0,1,0,0, 0, "t5r");
    chk("t5_lo", bus.lo, 32'h0);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      bit is, fl, mv;
      if (n % 80 == 0)
        do_reset();
      is = ($urandom % 4) == 0;
      fl = ($urandom % 12) == 0;
      mv = pend ? (($urandom % 4) == 0) : (($urandom % 40) == 0);
      cyc(is, fl, mv, {$urandom, $urandom},
          ($urandom % 5) == 0, ($urandom % 5) == 0,
          ($urandom % 6) == 0, ($urandom % 6) == 0,
          $urandom, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
